// File: rtl/retry_pkg.sv
// Shared helpers for the retry-budget controller: counter sizing, fault
// counter saturation value and ID-to-table-index slicing.
package retry_pkg;

  // Width of a per-ID retry counter able to hold 0..max_retries.
  function automatic int unsigned retry_cnt_width(input int unsigned max_retries);
    return $clog2(max_retries + 1);
  endfunction

  // All-ones saturation value for a counter of the given width.
  function automatic logic [31:0] fault_sat(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

  // Table index of an ID: everything below the parity/MSB bit.
  function automatic logic [31:0] idx_of(input logic [31:0] id, input int unsigned id_size);
    return id & ((32'd1 << (id_size - 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/retry_budget_table.sv
// Per-ID retry counter array. An accepted retry either increments or clears
// its entry; a completion clears its entry unless the retry hits the same one.
module retry_budget_table
  import retry_pkg::*;
#(
  parameter int unsigned Entries = 2,
  parameter int unsigned IdxW    = 1,
  parameter int unsigned CntW    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_rt_en,
  input  logic            i_rt_inc,
  input  logic [IdxW-1:0] i_rt_idx,
  input  logic            i_done_en,
  input  logic [IdxW-1:0] i_done_idx,
  output logic [CntW-1:0] o_rt_cnt_c
);

  logic [CntW-1:0] r_cnt [Entries];

  // Current count of the entry addressed by the incoming retry.
  assign o_rt_cnt_c = r_cnt[i_rt_idx];

  // Counter updates; the retry port has priority over done on a shared entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < Entries; i++) begin
        if (i_rt_en && (i_rt_idx == IdxW'(i))) begin
          r_cnt[i] <= i_rt_inc ? (r_cnt[i] + CntW'(1)) : '0;
        end else if (i_done_en && (i_done_idx == IdxW'(i))) begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/retry_budget_ctrl.sv
// Retry-budget controller: forwards retries while an ID is within budget,
// drops and reports them once the budget is spent; completions release it.
module retry_budget_ctrl
  import retry_pkg::*;
#(
  parameter int unsigned IDSize        = 2,
  parameter int unsigned MaxRetries    = 3,
  parameter int unsigned FaultCntWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [IDSize-1:0]        retry_id_i,
  input  logic                     retry_valid_i,
  output logic                     retry_ready_o,
  output logic [IDSize-1:0]        retry_id_o,
  output logic                     retry_valid_o,
  input  logic                     retry_ready_i,
  input  logic [IDSize-1:0]        done_id_i,
  input  logic                     done_valid_i,
  output logic                     fault_o,
  output logic [IDSize-1:0]        fault_id_o,
  output logic [FaultCntWidth-1:0] fault_count_o
);

  localparam int unsigned IdxW    = IDSize - 1;
  localparam int unsigned Entries = 1 << IdxW;
  localparam int unsigned CntW    = retry_cnt_width(MaxRetries);
  localparam logic [FaultCntWidth-1:0] FaultSat = FaultCntWidth'(fault_sat(FaultCntWidth));
  localparam logic [CntW-1:0]          CntMax   = CntW'(MaxRetries);

  logic                     r_out_valid;
  logic [IDSize-1:0]        r_out_id;
  logic                     r_fault;
  logic [IDSize-1:0]        r_fault_id;
  logic [FaultCntWidth-1:0] r_fault_cnt;

  logic            w_ready;
  logic            w_accept;
  logic            w_in_budget;
  logic            w_fwd;
  logic            w_drop;
  logic [IdxW-1:0] w_rt_idx;
  logic [IdxW-1:0] w_done_idx;
  logic [CntW-1:0] w_rt_cnt;

  // Accept and budget decision for the incoming retry.
  always_comb begin
    w_ready     = ~r_out_valid | retry_ready_i;
    w_accept    = retry_valid_i & w_ready;
    w_rt_idx    = IdxW'(idx_of(32'(retry_id_i), IDSize));
    w_done_idx  = IdxW'(idx_of(32'(done_id_i), IDSize));
    w_in_budget = (w_rt_cnt < CntMax);
    w_fwd       = w_accept & w_in_budget;
    w_drop      = w_accept & ~w_in_budget;
  end

  retry_budget_table #(
    .Entries (Entries),
    .IdxW    (IdxW),
    .CntW    (CntW)
  ) u_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_rt_en    (w_accept),
    .i_rt_inc   (w_in_budget),
    .i_rt_idx   (w_rt_idx),
    .i_done_en  (done_valid_i),
    .i_done_idx (w_done_idx),
    .o_rt_cnt_c (w_rt_cnt)
  );

  // One-entry forwarding register, held while valid and not ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
    end else if (w_fwd) begin
      r_out_valid <= 1'b1;
      r_out_id    <= retry_id_i;
    end else if (retry_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  // Drop reporting: single-cycle pulse with ID and a saturating counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fault     <= 1'b0;
      r_fault_id  <= '0;
      r_fault_cnt <= '0;
    end else begin
      r_fault <= w_drop;
      if (w_drop) begin
        r_fault_id <= retry_id_i;
        if (r_fault_cnt != FaultSat) begin
          r_fault_cnt <= r_fault_cnt + FaultCntWidth'(1);
        end
      end
    end
  end

  assign retry_ready_o = w_ready;
  assign retry_valid_o = r_out_valid;
  assign retry_id_o    = r_out_id;
  assign fault_o       = r_fault;
  assign fault_id_o    = r_fault_id;
  assign fault_count_o = r_fault_cnt;

endmodule

// File: tb/tb_retry_budget_ctrl.sv
// Bench for retry_budget_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared each cycle against a behavioural model.
module tb_retry_budget_ctrl;

  localparam int unsigned IdW  = 2;
  localparam int unsigned MaxR = 3;
  localparam int unsigned FcW  = 8;
  localparam int          FcMax = 255;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [IdW-1:0] retry_id_i;
  logic           retry_valid_i;
  logic           retry_ready_o;
  logic [IdW-1:0] retry_id_o;
  logic           retry_valid_o;
  logic           retry_ready_i;
  logic [IdW-1:0] done_id_i;
  logic           done_valid_i;
  logic           fault_o;
  logic [IdW-1:0] fault_id_o;
  logic [FcW-1:0] fault_count_o;

  always #5 clk_i = ~clk_i;

  retry_budget_ctrl #(
    .IDSize        (IdW),
    .MaxRetries    (MaxR),
    .FaultCntWidth (FcW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .retry_id_i    (retry_id_i),
    .retry_valid_i (retry_valid_i),
    .retry_ready_o (retry_ready_o),
    .retry_id_o    (retry_id_o),
    .retry_valid_o (retry_valid_o),
    .retry_ready_i (retry_ready_i),
    .done_id_i     (done_id_i),
    .done_valid_i  (done_valid_i),
    .fault_o       (fault_o),
    .fault_id_o    (fault_id_o),
    .fault_count_o (fault_count_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: forwards used per table slot since last release, plus visible outputs.
  int m_used [2];
  bit m_valid;
  int m_id;
  bit m_fault;
  int m_fid;
  int m_fcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_used[0] = 0; m_used[1] = 0;
    m_valid = 0; m_id = 0; m_fault = 0; m_fid = 0; m_fcnt = 0;
  endtask

  // One clock: drive inputs, compare DUT against the model, advance the model.
  task automatic step(input bit r, input bit v, input logic [1:0] id, input bit rdy,
                      input bit dv, input logic [1:0] did);
    int  idx;
    int  didx;
    bit  ready;
    bit  acc;
    @(negedge clk_i);
    rst_i = r; retry_valid_i = v; retry_id_i = id; retry_ready_i = rdy;
    done_valid_i = dv; done_id_i = did;
    #1;
    ready = !m_valid || rdy;
    chk("retry_ready_o", 32'(retry_ready_o), 32'(ready));
    chk("retry_valid_o", 32'(retry_valid_o), 32'(m_valid));
    chk("retry_id_o", 32'(retry_id_o), 32'(m_id));
    chk("fault_o", 32'(fault_o), 32'(m_fault));
    if (m_fault) chk("fault_id_o", 32'(fault_id_o), 32'(m_fid));
    chk("fault_count_o", 32'(fault_count_o), 32'(m_fcnt));
    if (r) begin
      model_reset();
    end else begin
      idx  = int'(id[0]);
      didx = int'(did[0]);
      acc  = v && ready;
      if (dv && !(acc && didx == idx)) m_used[didx] = 0;
      m_fault = 0;
      if (acc && m_used[idx] < int'(MaxR)) begin
        m_used[idx]++;
        m_valid = 1;
        m_id    = int'(id);
      end else begin
        if (acc) begin
          m_used[idx] = 0;
          m_fault = 1;
          m_fid   = int'(id);
          if (m_fcnt < FcMax) m_fcnt++;
        end
        if (rdy) m_valid = 0;
      end
    end
    @(posedge clk_i);
  endtask

  task automatic retry(input logic [1:0] id);
    step(0, 1, id, 1, 0, 2'b00);
  endtask

  task automatic idle();
    step(0, 0, 2'b00, 1, 0, 2'b00);
  endtask

  task automatic release_all();
    step(0, 0, 2'b00, 1, 1, 2'b00);
    step(0, 0, 2'b00, 1, 1, 2'b01);
  endtask

  // Literal expectation sampled just after the edge that produced it.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    rst_i = 1; retry_valid_i = 0; retry_id_i = '0; retry_ready_i = 1;
    done_valid_i = 0; done_id_i = '0;
    repeat (2) @(posedge clk_i);
    model_reset();
    @(negedge clk_i);
    rst_i = 0;
    lit("rst_valid", 32'(retry_valid_o), 0);
    lit("rst_id", 32'(retry_id_o), 0);
    lit("rst_ready", 32'(retry_ready_o), 1);
    lit("rst_fault", 32'(fault_o), 0);
    lit("rst_fault_id", 32'(fault_id_o), 0);
    lit("rst_fault_cnt", 32'(fault_count_o), 0);

    // Single retry forwarded next cycle.
    retry(2'b01); #1;
    lit("single_valid", 32'(retry_valid_o), 1);
    lit("single_id", 32'(retry_id_o), 1);
    // Budget exhaustion on the fourth retry.
    retry(2'b01); retry(2'b01); #1;
    lit("third_fault", 32'(fault_o), 0);
    retry(2'b01); #1;
    lit("drop_fault", 32'(fault_o), 1);
    lit("drop_fault_id", 32'(fault_id_o), 1);
    lit("drop_fault_cnt", 32'(fault_count_o), 1);
    lit("drop_no_fwd", 32'(retry_valid_o), 0);
    retry(2'b01); #1;
    lit("after_drop_fwd", 32'(retry_valid_o), 1);
    lit("after_drop_nofault", 32'(fault_o), 0);

    // Completion releases the budget.
    release_all();
    retry(2'b01); retry(2'b01);
    step(0, 0, 2'b00, 1, 1, 2'b01);
    for (int k = 0; k < 3; k++) begin
      retry(2'b01); #1;
      lit("done_fwd", 32'(retry_valid_o), 1);
      lit("done_nofault", 32'(fault_o), 0);
    end
    lit("done_cnt", 32'(fault_count_o), 1);

    // Stall: output held, input not accepted.
    release_all();
    step(0, 1, 2'b10, 0, 0, 2'b00);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 2'b11, 0, 0, 2'b00); #1;
      lit("stall_ready", 32'(retry_ready_o), 0);
      lit("stall_valid", 32'(retry_valid_o), 1);
      lit("stall_id", 32'(retry_id_o), 2);
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      retry(2'b11); #1;
      lit("stall_nocount", 32'(fault_o), 0);
    end

    // Same-index retry and done: retry wins.
    release_all();
    for (int k = 0; k < 3; k++) step(0, 1, 2'b00, 1, 1, 2'b00);
    retry(2'b00); #1;
    lit("same_idx_fault", 32'(fault_o), 1);
    lit("same_idx_cnt", 32'(fault_count_o), 2);
    // Different indices: both apply.
    release_all();
    retry(2'b01); retry(2'b01); retry(2'b01);
    step(0, 1, 2'b00, 1, 1, 2'b01);
    retry(2'b01); #1;
    lit("diff_idx_nofault", 32'(fault_o), 0);
    lit("diff_idx_fwd", 32'(retry_id_o), 1);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), 2'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), 2'($urandom));
    end

    // Saturation: 260 drops from a cleared counter.
    step(1, 0, 2'b00, 1, 0, 2'b00);
    for (int k = 0; k < 260 * 4; k++) retry(2'b10);
    #1;
    lit("sat_cnt", 32'(fault_count_o), 255);

    // Reset mid-stream.
    retry(2'b11);
    step(1, 1, 2'b01, 1, 0, 2'b00); #1;
    lit("mid_rst_valid", 32'(retry_valid_o), 0);
    lit("mid_rst_id", 32'(retry_id_o), 0);
    lit("mid_rst_ready", 32'(retry_ready_o), 1);
    lit("mid_rst_fault", 32'(fault_o), 0);
    lit("mid_rst_fault_id", 32'(fault_id_o), 0);
    lit("mid_rst_cnt", 32'(fault_count_o), 0);
    for (int k = 0; k < 20; k++) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/retry_budget_ctrl.md
# retry_budget_ctrl

Retry-budget controller inserted on the retry channel between a `retry_end`/`retry_start` pair. It counts how often each in-flight operation ID has been retried and forwards retry requests to `retry_start` only while that ID is within budget. Once an ID exceeds its budget, further retries are dropped and a fault is reported, so a permanent fault in the protected datapath cannot livelock the pipeline. Completion notifications from downstream release an ID's budget.

## Interface
Parameters:
- `IDSize`, default 2: ID width including the parity/MSB bit; the table has 2**(IDSize-1) entries, indexed by `id[IDSize-2:0]`.
- `MaxRetries`, default 3: number of retries allowed per ID before it is dropped; must be ≥1.
- `FaultCntWidth`, default 8: width of the saturating dropped-operation counter.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `retry_id_i` in IDSize: retry ID arriving from `retry_end`.
- `retry_valid_i` in 1: retry request valid.
- `retry_ready_o` out 1: retry request accepted.
- `retry_id_o` out IDSize: ID forwarded to `retry_start`.
- `retry_valid_o` out 1: forwarded retry valid.
- `retry_ready_i` in 1: `retry_start` accepts.
- `done_id_i` in IDSize: ID of an operation that has left the pipeline successfully.
- `done_valid_i` in 1: completion strobe; always accepted, no ready.
- `fault_o` out 1: one-cycle pulse when a retry is dropped.
- `fault_id_o` out IDSize: ID of the dropped retry, valid while `fault_o` is high.
- `fault_count_o` out FaultCntWidth: saturating count of dropped retries.

## Operation
- Per-entry retry counter, width $clog2(MaxRetries+1), all entries 0 after reset.
- One-entry output register (`out_valid_q`, `out_id_q`) drives `retry_valid_o` and `retry_id_o`.
- `retry_ready_o = ~out_valid_q | retry_ready_i`.
- A retry is accepted when `retry_valid_i & retry_ready_o`. With `idx = retry_id_i[IDSize-2:0]`:
  - If `cnt[idx] < MaxRetries`: `cnt[idx]++`, load `out_id_q <= retry_id_i`, set `out_valid_q <= 1`.
  - Otherwise: drop the retry and do not load the output register. Clear `cnt[idx] <= 0`, pulse `fault_o` and `fault_id_o` next cycle, and increment `fault_count_o`, saturating at all-ones.
- Output register: `out_valid_q` clears on `retry_ready_i` when no new accepted forward occurs in the same cycle. The value is held stable while valid and not ready (AXI-style).
- Completion: `done_valid_i` clears `cnt[done_id_i[IDSize-2:0]] <= 0`.
- Simultaneous retry accept and done on the same index: the retry update wins. Different indices: both apply.
- No FSM beyond the output-register valid bit; the table is pure counters.
- Reset mid-operation: the output register and all counters clear; an in-flight forwarded retry is lost. The system integrator resets the `retry_start`/`retry_end` pair together with this block.

## Timing
- Forwarding latency: 1 cycle, from accept to `retry_valid_o`.
- Full throughput: one retry per cycle when `retry_ready_i` is held high.
- `fault_o` asserts exactly 1 cycle after the dropping accept and lasts 1 cycle. Back-to-back drops give consecutive pulses.
- `fault_count_o` updates in the same cycle `fault_o` asserts.
- Reset values: `retry_valid_o=0`, `retry_id_o=0`, `retry_ready_o=1`, `fault_o=0`, `fault_id_o=0`, `fault_count_o=0`.
- No combinational path from `retry_valid_i` or `retry_id_i` to any output.
- There is a combinational path `retry_ready_i -> retry_ready_o`, consistent with `retry_start`'s `ready_i`-based `retry_ready_o`.

## Structure
- Shared package `retry_pkg`: `retry_cnt_t` width function, fault-counter saturation constant, `idx_of(id)` slicing helper.
- One sub-module `retry_budget_table`: the counter array with an increment/clear port and a done-clear port (priority resolved inside). The top level holds the output register and fault logic.
- Reuse the team's `FF` register macro variants with synchronous active-high reset.

## Test plan
- Single retry, ID 2'b01, `retry_ready_i=1` -> `retry_valid_o=1`, `retry_id_o=01` next cycle, `cnt[1]=1`.
- Same ID retried 4 times with MaxRetries=3 -> first 3 forwarded; 4th dropped, `fault_o` pulses with `fault_id_o=01`, `fault_count_o=1`, `cnt[1]=0`.
- Retry ID 01 twice, then `done_valid_i` with ID 01, then 3 more retries -> all forwarded, no fault.
- `retry_ready_i=0` for 5 cycles with a retry pending -> `retry_valid_o` and `retry_id_o` stable, `retry_ready_o=0`, no counter change for the stalled input.
- Same cycle: retry accept on idx 0 and done on idx 0 -> `cnt[0]` increments (not cleared); on different indices, both apply.
- Force 260 drops with FaultCntWidth=8 -> `fault_count_o` saturates at 255. Assert `rst_i` for one cycle mid-stream -> all outputs at reset values on the next cycle.
